// File: rtl/lfsr_ctrl_pkg.sv
// Shared state encoding and Moore output decode for the LFSR sequencing controller.
package lfsr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_LOAD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic lfsr_rst;
    logic rst;
    logic en;
  } outs_t;

  function automatic outs_t decode_outs(input state_e s);
    outs_t o;
    case (s)
      ST_SEED: o = '{lfsr_rst: 1'b0, rst: 1'b1, en: 1'b0};
      ST_LOAD: o = '{lfsr_rst: 1'b0, rst: 1'b1, en: 1'b0};
      ST_RUN:  o = '{lfsr_rst: 1'b0, rst: 1'b0, en: 1'b1};
      default: o = '{lfsr_rst: 1'b1, rst: 1'b1, en: 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lfsr_ctrl_cnt.sv
// LOAD dwell counter: cleared on LOAD entry, counts each LOAD cycle, flags the last one.
module lfsr_ctrl_cnt
  import lfsr_ctrl_pkg::*;
#(
  parameter int LOAD_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal on the last LOAD cycle, so LOAD lasts exactly LOAD_CYCLES cycles.
  assign tc_o = (cnt_q == CNT_W'(LOAD_CYCLES - 1));

endmodule

// File: rtl/lfsr_ctrl_fsm.sv
// Moore controller sequencing an external LFSR: IDLE -> SEED -> LOAD -> RUN.
// Optional state_o output when LFSR_CTRL_FSM_STATE_OUT_EN is defined.
module lfsr_ctrl_fsm
  import lfsr_ctrl_pkg::*;
#(
  parameter int LOAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       lfsr_load,
  output logic       lfsr_rst,
  output logic       rst,
  output logic       en
`ifdef LFSR_CTRL_FSM_STATE_OUT_EN
  ,
  output logic [1:0] state_o
`endif
);

  state_e state_q, state_d;
  logic   cnt_clr, cnt_inc, cnt_tc;
  outs_t  outs;

  lfsr_ctrl_cnt #(
    .LOAD_CYCLES(LOAD_CYCLES)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .tc_o  (cnt_tc)
  );

  // Dropping start aborts from any non-IDLE state and takes priority.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SEED;
      end
      ST_SEED: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (lfsr_load) begin
          state_d = ST_LOAD;
          cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        cnt_inc = 1'b1;
        if (!start) begin
          state_d = ST_IDLE;
        end else if (cnt_tc) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign outs     = decode_outs(state_q);
  assign lfsr_rst = outs.lfsr_rst;
  assign rst      = outs.rst;
  assign en       = outs.en;

`ifdef LFSR_CTRL_FSM_STATE_OUT_EN
  assign state_o = state_q;
`endif

endmodule

// File: tb/tb_lfsr_ctrl_fsm.sv
// Directed bench for lfsr_ctrl_fsm: expected outputs queued at stimulus time, popped at sample time.
`timescale 1ns/1ps
module tb_lfsr_ctrl_fsm;

  typedef struct packed {
    logic [2:0] outs;  // {lfsr_rst, rst, en}
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic lfsr_load = 1'b0;
  logic lfsr_rst, rst, en;
`ifdef LFSR_CTRL_FSM_STATE_OUT_EN
  logic [1:0] state_o;
`endif

  int tests = 0;
  int fails = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  localparam logic [2:0] O_IDLE = 3'b110;
  localparam logic [2:0] O_SEED = 3'b010;
  localparam logic [2:0] O_LOAD = 3'b010;
  localparam logic [2:0] O_RUN  = 3'b001;

  lfsr_ctrl_fsm #(.LOAD_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .lfsr_load (lfsr_load),
    .lfsr_rst  (lfsr_rst),
    .rst       (rst),
    .en        (en)
`ifdef LFSR_CTRL_FSM_STATE_OUT_EN
    ,
    .state_o   (state_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic at(input int t);
    if ($time < t) #(t - $time);
  endtask

  task automatic expect_st(input logic [2:0] o, input logic [1:0] s, input string tag);
    exp_t e;
    e.outs = o;
    e.st   = s;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_at(input int t);
    exp_t  e;
    string tag;
    logic [2:0] obs;
    at(t);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty at %0t: observed empty queue, expected an entry", $time);
      return;
    end
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = {lfsr_rst, rst, en};
    tests++;
    assert (obs === e.outs) else begin
      fails++;
      $error("FAIL %s @%0t: observed lfsr_rst/rst/en=%b expected %b", tag, $time, obs, e.outs);
    end
`ifdef LFSR_CTRL_FSM_STATE_OUT_EN
    tests++;
    assert (state_o === e.st) else begin
      fails++;
      $error("FAIL %s_state @%0t: observed state_o=%0d expected %0d", tag, $time, state_o, e.st);
    end
`endif
  endtask

  initial begin
    // Reset held to 41 ns
    expect_st(O_IDLE, 2'd0, "reset_hold");  check_at(20);
    at(41); reset = 1'b0;
    expect_st(O_IDLE, 2'd0, "idle_start0"); check_at(50);
    expect_st(O_IDLE, 2'd0, "idle_stay");   check_at(60);

    // Seeding
    at(61); start = 1'b1;
    expect_st(O_SEED, 2'd1, "seed_enter");  check_at(70);
    expect_st(O_SEED, 2'd1, "seed_hold");   check_at(90);

    // Load for 2 cycles, then RUN held to 500 ns
    at(101); lfsr_load = 1'b1;
    expect_st(O_LOAD, 2'd2, "load_c1");     check_at(110);
    expect_st(O_LOAD, 2'd2, "load_c2");     check_at(120);
    expect_st(O_RUN,  2'd3, "run_enter");   check_at(130);
    at(141); lfsr_load = 1'b0;
    for (int t = 200; t <= 500; t += 100) begin
      expect_st(O_RUN, 2'd3, "run_hold");   check_at(t);
    end

    // Abort from RUN
    at(501); start = 1'b0;
    expect_st(O_RUN,  2'd3, "run_abort_pre");  check_at(503);
    expect_st(O_IDLE, 2'd0, "run_abort");      check_at(510);

    // Abort from SEED
    at(511); start = 1'b1;
    expect_st(O_SEED, 2'd1, "seed2");          check_at(520);
    at(521); start = 1'b0;
    expect_st(O_SEED, 2'd1, "seed_abort_pre"); check_at(523);
    expect_st(O_IDLE, 2'd0, "seed_abort");     check_at(530);

    // Abort from LOAD
    at(531); start = 1'b1;
    at(541); lfsr_load = 1'b1;
    expect_st(O_LOAD, 2'd2, "load3");          check_at(550);
    at(551); start = 1'b0; lfsr_load = 1'b0;
    expect_st(O_IDLE, 2'd0, "load_abort");     check_at(560);

    // start and lfsr_load together in IDLE: SEED first
    at(561); start = 1'b1; lfsr_load = 1'b1;
    expect_st(O_SEED, 2'd1, "both_seed");      check_at(570);
    expect_st(O_LOAD, 2'd2, "both_load1");     check_at(580);
    expect_st(O_LOAD, 2'd2, "both_load2");     check_at(590);
    expect_st(O_RUN,  2'd3, "both_run");       check_at(600);

    // Async reset pulse mid-RUN, between edges
    at(602); reset = 1'b1;
    expect_st(O_IDLE, 2'd0, "arst_run");       check_at(603);
    at(604); reset = 1'b0;
    expect_st(O_IDLE, 2'd0, "arst_run_hold");  check_at(604);
    expect_st(O_SEED, 2'd1, "post_arst_seed"); check_at(610);

    // Async reset pulse mid-LOAD
    expect_st(O_LOAD, 2'd2, "load4");          check_at(620);
    at(622); reset = 1'b1;
    expect_st(O_IDLE, 2'd0, "arst_load");      check_at(623);
    at(624); reset = 1'b0; start = 1'b0; lfsr_load = 1'b0;
    expect_st(O_IDLE, 2'd0, "arst_load_idle"); check_at(630);

    // Fresh run: counter restarts cleanly after reset
    at(631); start = 1'b1; lfsr_load = 1'b1;
    expect_st(O_SEED, 2'd1, "rerun_seed");     check_at(640);
    expect_st(O_LOAD, 2'd2, "rerun_load1");    check_at(650);
    expect_st(O_LOAD, 2'd2, "rerun_load2");    check_at(660);
    expect_st(O_RUN,  2'd3, "rerun_run");      check_at(670);

    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover: observed %0d entries, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_ctrl_fsm.md
LFSR_CTRL_FSM -- requirements
Module: lfsr_ctrl_fsm

Interface
REQ-001 SHALL have parameter LOAD_CYCLES, default 2: number of cycles spent in LOAD (legal range 1-255).
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high: port clk, input, 1 bit, rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, level request to begin a run.
REQ-005 SHALL have port lfsr_load, input, 1 bit, level indication that the LFSR seed is to be captured.
REQ-006 SHALL have port lfsr_rst, output, 1 bit, holds the external LFSR in reset.
REQ-007 SHALL have port rst, output, 1 bit, holds the downstream datapath in reset.
REQ-008 SHALL have port en, output, 1 bit, enables the downstream datapath.

Function
REQ-009 SHALL be a Moore machine; outputs decode only from the registered state, with no combinational path from inputs to outputs.
REQ-010 SHALL implement four states: IDLE, SEED, LOAD and RUN.
REQ-011 SHALL drive the following outputs (lfsr_rst/rst/en) per state: IDLE 1/1/0; SEED 0/1/0; LOAD 0/1/0; RUN 0/0/1.
REQ-012 SHALL, in IDLE, move to SEED on the first rising edge with start=1; otherwise it stays in IDLE.
REQ-013 SHALL, in SEED, move to LOAD on the first edge with lfsr_load=1; otherwise it stays in SEED (the LFSR free-runs).
REQ-014 SHALL, in LOAD, stay exactly LOAD_CYCLES cycles, counted by an internal counter cleared on LOAD entry, then enter RUN.
REQ-015 SHALL, in RUN, stay in RUN while start=1 and return to IDLE on the first edge with start=0.
REQ-016 SHALL give start=0 in SEED or LOAD priority and return to IDLE (abort).
REQ-017 SHALL ignore lfsr_load outside SEED.
REQ-018 SHALL, if start and lfsr_load both rise on the same edge in IDLE, enter SEED only; LOAD requires lfsr_load sampled in SEED.
REQ-019 SHALL latch output changes one clock after the deciding input edge.
REQ-020 SHALL force any illegal state encoding to IDLE on the next edge.

Reset
REQ-021 SHALL, while reset=1, asynchronously force state to IDLE and the counter to 0, regardless of clk.
REQ-022 SHALL hold outputs at lfsr_rst=1, rst=1, en=0 during reset.
REQ-023 SHALL treat reset asserted mid-RUN or mid-LOAD identically, dropping en within the same time step.
REQ-024 SHALL, after reset deassertion, make the first transition at the next rising edge per REQ-012.

Configuration
REQ-025 SHALL, when macro LFSR_CTRL_FSM_STATE_OUT_EN is defined, add output port state_o (2 bits): the current state encoding (IDLE=0, SEED=1, LOAD=2, RUN=3).
REQ-026 SHALL, without LFSR_CTRL_FSM_STATE_OUT_EN, omit the state_o port; all other behaviour is identical.

Structure
REQ-027 SHALL place the state enum typedef and the state encodings in shared package lfsr_ctrl_pkg.
REQ-028 SHALL keep the LOAD_CYCLES counter in a sub-module named lfsr_ctrl_cnt (load/clear, terminal-count flag); the state register and output decode live in the top.

Verification
REQ-029 SHALL test reset: reset=1 for 41 ns (10 ns clock) -> outputs 1/1/0, and they remain 1/1/0 with start=0.
REQ-030 SHALL test seeding: start=1 at 61 ns -> after the next edge, outputs 0/1/0 (SEED), held while lfsr_load=0.
REQ-031 SHALL test the run path: lfsr_load=1 at 101 ns, LOAD_CYCLES=2 -> 0/1/0 for 2 cycles, then 0/0/1 (RUN) persisting to 500 ns.
REQ-032 SHALL test abort: start drops to 0 in SEED -> IDLE outputs 1/1/0 one cycle later; the same in RUN.
REQ-033 SHALL test async reset mid-RUN: reset pulses between clock edges -> outputs 1/1/0 immediately and the state is IDLE.
REQ-034 SHALL test configuration: with LFSR_CTRL_FSM_STATE_OUT_EN defined, state_o steps 0->1->2->3 along the REQ-031 sequence.
